// File: rtl/csr_timer_bank_if.sv
// CSR write/read channel shared with csr on the idex side.
//   csr_we_i    : write enable
//   csr_addr_i  : 12-bit CSR address
//   csr_wdata_i : write data, captured at posedge clk
//   csr_rdata_o : combinational read data for csr_addr_i
interface csr_timer_bank_if;
   logic        csr_we_i;
   logic [11:0] csr_addr_i;
   logic [31:0] csr_wdata_i;
   logic [31:0] csr_rdata_o;

   modport master (
      output csr_we_i,
      output csr_addr_i,
      output csr_wdata_i,
      input  csr_rdata_o
   );

   modport slave (
      input  csr_we_i,
      input  csr_addr_i,
      input  csr_wdata_i,
      output csr_rdata_o
   );
endinterface

// File: rtl/csr_timer_bank.sv
// Bank of NCH CSR-mapped compare timers with per-channel prescaler,
// one-shot/periodic mode, sticky PEND/OVR flags and masked IRQs.
//   clk, rst_n  : clock, asynchronous active-low reset
//   csr         : CSR write/read channel (slave side); window CSR_BASE .. CSR_BASE+8*NCH-1
//   hx_valid_i  : writeback-valid strobe, gates irq_o updates
//   irq_o       : per-channel registered PEND & IE
//   tmr_irq_o   : OR of irq_o
module csr_timer_bank #(
   parameter int unsigned NCH      = 4,
   parameter int unsigned CNT_W    = 64,
   parameter int unsigned PRE_W    = 8,
   parameter logic [11:0] CSR_BASE = 12'hBC0
) (
   input  logic              clk,
   input  logic              rst_n,
   csr_timer_bank_if.slave   csr,
   input  logic              hx_valid_i,
   output logic [NCH-1:0]    irq_o,
   output logic              tmr_irq_o
);

   localparam int unsigned WIN  = 8 * NCH;
   localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

   logic [NCH-1:0]   en_q, en_d, mode_q, mode_d, ie_q, ie_d;
   logic [NCH-1:0]   pend_q, pend_d, ovr_q, ovr_d;
   logic [PRE_W-1:0] presc_q [NCH];
   logic [PRE_W-1:0] presc_d [NCH];
   logic [PRE_W-1:0] pcnt_q  [NCH];
   logic [PRE_W-1:0] pcnt_d  [NCH];
   logic [CNT_W-1:0] cnt_q   [NCH];
   logic [CNT_W-1:0] cnt_d   [NCH];
   logic [CNT_W-1:0] cmp_q   [NCH];
   logic [CNT_W-1:0] cmp_d   [NCH];

   logic [11:0]      rel;
   logic             in_win;
   logic [2:0]       off;
   logic [CH_W-1:0]  sel;
   logic [NCH-1:0]   wr, tick, match;
   logic [63:0]      v;
   logic [31:0]      rdata;

   // Address window decode
   always_comb begin
      rel    = csr.csr_addr_i - CSR_BASE;
      in_win = (csr.csr_addr_i >= CSR_BASE) && (rel < 12'(WIN));
      off    = rel[2:0];
      sel    = rel[3 +: CH_W];
   end

   // Per-channel write select, prescaler tick and compare match
   always_comb begin
      wr    = '0;
      tick  = '0;
      match = '0;
      for (int i = 0; i < NCH; i++) begin
         wr[i]    = csr.csr_we_i && in_win && (sel == CH_W'(i));
         tick[i]  = en_q[i] && (pcnt_q[i] == presc_q[i]);
         match[i] = (cnt_q[i] == cmp_q[i]);
      end
   end

   // Next state: W1C first, then hardware events, then CSR writes that win over them
   always_comb begin
      v       = '0;
      en_d    = en_q;
      mode_d  = mode_q;
      ie_d    = ie_q;
      pend_d  = pend_q;
      ovr_d   = ovr_q;
      presc_d = presc_q;
      pcnt_d  = pcnt_q;
      cnt_d   = cnt_q;
      cmp_d   = cmp_q;
      for (int i = 0; i < NCH; i++) begin
         if (wr[i] && (off == 3'd6)) begin
            pend_d[i] = pend_q[i] & ~csr.csr_wdata_i[0];
            ovr_d[i]  = ovr_q[i]  & ~csr.csr_wdata_i[1];
         end

         if (en_q[i]) begin
            pcnt_d[i] = tick[i] ? '0 : pcnt_q[i] + PRE_W'(1);
         end

         if (tick[i]) begin
            if (match[i]) begin
               pend_d[i] = 1'b1;
               ovr_d[i]  = ovr_d[i] | pend_q[i];
               if (mode_q[i]) cnt_d[i] = '0;
               else           en_d[i]  = 1'b0;
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end

         if (wr[i]) begin
            case (off)
               3'd0: begin
                  mode_d[i] = csr.csr_wdata_i[1];
                  ie_d[i]   = csr.csr_wdata_i[2];
                  // a one-shot self-disable in this cycle overrides the write
                  if (!(tick[i] && match[i] && !mode_q[i])) en_d[i] = csr.csr_wdata_i[0];
                  if (csr.csr_wdata_i[0] && !en_q[i]) pcnt_d[i] = '0;
               end
               3'd1: presc_d[i] = csr.csr_wdata_i[PRE_W-1:0];
               3'd2: begin
                  v        = 64'(cnt_q[i]);
                  v[31:0]  = csr.csr_wdata_i;
                  cnt_d[i] = CNT_W'(v);
               end
               3'd3: begin
                  v        = 64'(cnt_q[i]);
                  v[63:32] = csr.csr_wdata_i;
                  cnt_d[i] = CNT_W'(v);
               end
               3'd4: begin
                  v        = 64'(cmp_q[i]);
                  v[31:0]  = csr.csr_wdata_i;
                  cmp_d[i] = CNT_W'(v);
               end
               3'd5: begin
                  v        = 64'(cmp_q[i]);
                  v[63:32] = csr.csr_wdata_i;
                  cmp_d[i] = CNT_W'(v);
               end
               default: ;
            endcase
         end
      end
   end

   // Channel state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q   <= '0;
         mode_q <= '0;
         ie_q   <= '0;
         pend_q <= '0;
         ovr_q  <= '0;
         for (int i = 0; i < NCH; i++) begin
            presc_q[i] <= '0;
            pcnt_q[i]  <= '0;
            cnt_q[i]   <= '0;
            cmp_q[i]   <= '1;
         end
      end else begin
         en_q    <= en_d;
         mode_q  <= mode_d;
         ie_q    <= ie_d;
         pend_q  <= pend_d;
         ovr_q   <= ovr_d;
         presc_q <= presc_d;
         pcnt_q  <= pcnt_d;
         cnt_q   <= cnt_d;
         cmp_q   <= cmp_d;
      end
   end

   // Masked interrupt requests, sampled only on valid writeback
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_o <= '0;
      end else if (hx_valid_i) begin
         irq_o <= pend_q & ie_q;
      end
   end

   assign tmr_irq_o = |irq_o;

   // Combinational read mux; bits above CNT_W come out of the zero-extension
   always_comb begin
      rdata = '0;
      if (in_win) begin
         for (int i = 0; i < NCH; i++) begin
            if (sel == CH_W'(i)) begin
               case (off)
                  3'd0: rdata = {29'd0, ie_q[i], mode_q[i], en_q[i]};
                  3'd1: rdata = 32'(presc_q[i]);
                  3'd2: rdata = 32'(64'(cnt_q[i]));
                  3'd3: rdata = 32'(64'(cnt_q[i]) >> 32);
                  3'd4: rdata = 32'(64'(cmp_q[i]));
                  3'd5: rdata = 32'(64'(cmp_q[i]) >> 32);
                  3'd6: rdata = {30'd0, ovr_q[i], pend_q[i]};
                  default: rdata = '0;
               endcase
            end
         end
      end
   end

   assign csr.csr_rdata_o = rdata;

endmodule
